reduction_stream_acc: RTL and testbench



---
 rtl/reduction_pkg.sv | 9 +
 rtl/reduction_stream_acc_popcount_word.sv | 17 +
 rtl/reduction_stream_acc.sv | 162 ++++++++++++++++
 tb/tb_reduction_stream_acc.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/reduction_pkg.sv
// Shared definitions for the streaming reduction accumulator.
package reduction_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/reduction_stream_acc_popcount_word.sv
// Combinational population count of one WIDTH-bit word, zero-extended to OW bits.
module popcount_word #(
  parameter int WIDTH = 4,
  parameter int OW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [OW-1:0]    ones
);

  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ones = ones + OW'(data[i]);
    end
  end

endmodule

// File: rtl/reduction_stream_acc.sv
// Accumulates AND/OR/XOR reductions, ones count and word count over a framed
// input stream, then presents one registered result beat per frame.
module reduction_stream_acc
  import reduction_pkg::*;
#(
  parameter  int WIDTH     = 4,
  parameter  int MAX_WORDS = 4,
  localparam int CW        = $clog2(MAX_WORDS + 1),
  localparam int OW        = $clog2(WIDTH * MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_and,
  output logic             out_or,
  output logic             out_xor,
  output logic [OW-1:0]    out_ones,
  output logic [CW-1:0]    out_words,
  output logic             out_trunc
);

  state_e        state_q, state_d;
  logic          and_q, and_d;
  logic          or_q, or_d;
  logic          xor_q, xor_d;
  logic [OW-1:0] ones_q, ones_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          out_valid_q, out_valid_d;
  logic          out_and_q, out_and_d;
  logic          out_or_q, out_or_d;
  logic          out_xor_q, out_xor_d;
  logic [OW-1:0] out_ones_q, out_ones_d;
  logic [CW-1:0] out_words_q, out_words_d;
  logic          out_trunc_q, out_trunc_d;

  logic          accept;
  logic [OW-1:0] beat_ones;
  logic          and_nx, or_nx, xor_nx;
  logic [OW-1:0] ones_nx;
  logic [CW-1:0] cnt_nx;
  logic          close_frame;

  popcount_word #(
    .WIDTH (WIDTH),
    .OW    (OW)
  ) u_popcount (
    .data (in_data),
    .ones (beat_ones)
  );

  assign in_ready = (state_q == ST_ACCUM) && !rst;
  assign accept   = in_valid && in_ready;

  // Accumulator values including the current beat; cnt_q < MAX_WORDS always,
  // so cnt_nx fits in CW bits.
  always_comb begin
    and_nx      = and_q & (&in_data);
    or_nx       = or_q | (|in_data);
    xor_nx      = xor_q ^ (^in_data);
    ones_nx     = ones_q + beat_ones;
    cnt_nx      = cnt_q + CW'(1);
    close_frame = in_last || (cnt_nx == CW'(MAX_WORDS));
  end

  always_comb begin
    state_d     = state_q;
    and_d       = and_q;
    or_d        = or_q;
    xor_d       = xor_q;
    ones_d      = ones_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_and_d   = out_and_q;
    out_or_d    = out_or_q;
    out_xor_d   = out_xor_q;
    out_ones_d  = out_ones_q;
    out_words_d = out_words_q;
    out_trunc_d = out_trunc_q;

    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          if (close_frame) begin
            out_and_d   = and_nx;
            out_or_d    = or_nx;
            out_xor_d   = xor_nx;
            out_ones_d  = ones_nx;
            out_words_d = cnt_nx;
            out_trunc_d = !in_last;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
            and_d       = 1'b1;
            or_d        = 1'b0;
            xor_d       = 1'b0;
            ones_d      = '0;
            cnt_d       = '0;
          end else begin
            and_d  = and_nx;
            or_d   = or_nx;
            xor_d  = xor_nx;
            ones_d = ones_nx;
            cnt_d  = cnt_nx;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      and_q       <= 1'b1;
      or_q        <= 1'b0;
      xor_q       <= 1'b0;
      ones_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_and_q   <= 1'b0;
      out_or_q    <= 1'b0;
      out_xor_q   <= 1'b0;
      out_ones_q  <= '0;
      out_words_q <= '0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      and_q       <= and_d;
      or_q        <= or_d;
      xor_q       <= xor_d;
      ones_q      <= ones_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_and_q   <= out_and_d;
      out_or_q    <= out_or_d;
      out_xor_q   <= out_xor_d;
      out_ones_q  <= out_ones_d;
      out_words_q <= out_words_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_and   = out_and_q;
  assign out_or    = out_or_q;
  assign out_xor   = out_xor_q;
  assign out_ones  = out_ones_q;
  assign out_words = out_words_q;
  assign out_trunc = out_trunc_q;

endmodule

// File: tb/tb_reduction_stream_acc.sv
// Self-checking bench for reduction_stream_acc (WIDTH=4, MAX_WORDS=4) against a
// frame-level reference model built from queued words.
module tb_reduction_stream_acc;

  localparam int WIDTH     = 4;
  localparam int MAX_WORDS = 4;
  localparam int CW        = $clog2(MAX_WORDS + 1);
  localparam int OW        = $clog2(WIDTH * MAX_WORDS + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic             out_and;
  logic             out_or;
  logic             out_xor;
  logic [OW-1:0]    out_ones;
  logic [CW-1:0]    out_words;
  logic             out_trunc;

  int total_checks = 0;
  int fail_checks  = 0;

  logic [WIDTH-1:0] frame[$];
  int e_and, e_or, e_xor, e_ones, e_words, e_trunc;

  always #5 clk = ~clk;

  reduction_stream_acc #(
    .WIDTH     (WIDTH),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_and   (out_and),
    .out_or    (out_or),
    .out_xor   (out_xor),
    .out_ones  (out_ones),
    .out_words (out_words),
    .out_trunc (out_trunc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp)
    else begin
      fail_checks++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: the frame closes on last or when MAX_WORDS words are held; the
  // result is computed bit by bit over the whole frame.
  task automatic model_accept(input logic [WIDTH-1:0] d, input logic l, output bit closed);
    frame.push_back(d);
    closed = l || (frame.size() == MAX_WORDS);
    if (closed) begin
      e_and  = 1;
      e_or   = 0;
      e_ones = 0;
      foreach (frame[w]) begin
        for (int b = 0; b < WIDTH; b++) begin
          if (frame[w][b]) begin
            e_or = 1;
            e_ones++;
          end else begin
            e_and = 0;
          end
        end
      end
      e_xor   = e_ones % 2;
      e_words = frame.size();
      e_trunc = l ? 0 : 1;
      frame.delete();
    end
  endtask

  task automatic check_result(input string tag);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".and"},   out_and,   e_and);
    chk({tag, ".or"},    out_or,    e_or);
    chk({tag, ".xor"},   out_xor,   e_xor);
    chk({tag, ".ones"},  out_ones,  e_ones);
    chk({tag, ".words"}, out_words, e_words);
    chk({tag, ".trunc"}, out_trunc, e_trunc);
  endtask

  // Offers one beat from a negedge, waits (bounded) for in_ready, and checks the
  // result one cycle after a closing beat. stall holds out_ready low afterwards.
  task automatic send_beat(input string tag, input logic [WIDTH-1:0] d, input logic l,
                           input bit stall, output bit closed);
    int n;
    closed = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".in_ready"}, in_ready, 1);
    if (in_ready) begin
      @(posedge clk);
      model_accept(d, l, closed);
      @(negedge clk);
      out_ready = stall ? 1'b0 : 1'b1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (closed) check_result(tag);
  endtask

  initial begin
    bit c;
    int k;
    logic [WIDTH-1:0] d;
    logic l;
    bit st;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset.out_valid", out_valid, 0);
    chk("reset.in_ready",  in_ready,  0);
    chk("reset.out_and",   out_and,   0);
    chk("reset.out_ones",  out_ones,  0);
    chk("reset.out_words", out_words, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset.in_ready", in_ready, 1);

    // Single-beat frame
    send_beat("t1", 4'b1011, 1'b1, 1'b0, c);
    chk("t1.ones_const", out_ones, 3);
    chk("t1.xor_const",  out_xor,  1);

    // Two-beat frame, then a cleared single-beat frame
    send_beat("t2a", 4'b1111, 1'b0, 1'b0, c);
    send_beat("t2a", 4'b1111, 1'b1, 1'b0, c);
    chk("t2a.ones_const", out_ones, 8);
    send_beat("t2b", 4'b0000, 1'b1, 1'b0, c);
    chk("t2b.ones_const", out_ones, 0);

    // MAX_WORDS truncation, then in_last coinciding with the limit
    for (int i = 0; i < MAX_WORDS; i++) send_beat("t3a", 4'b0001, 1'b0, 1'b0, c);
    chk("t3a.trunc_const", out_trunc, 1);
    for (int i = 0; i < MAX_WORDS; i++)
      send_beat("t3b", 4'b0001, (i == MAX_WORDS - 1), 1'b0, c);
    chk("t3b.trunc_const", out_trunc, 0);

    // Backpressure: result held while a beat is offered and refused
    send_beat("t4", 4'b0110, 1'b1, 1'b1, c);
    in_valid = 1'b1;
    in_data  = 4'b1111;
    in_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t4.hold_valid",  out_valid, 1);
      chk("t4.hold_ready",  in_ready,  0);
      chk("t4.hold_ones",   out_ones,  e_ones);
      chk("t4.hold_words",  out_words, e_words);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4.drop_valid", out_valid, 0);
    chk("t4.in_ready",   in_ready,  1);
    @(posedge clk);
    model_accept(4'b1111, 1'b1, c);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_result("t4.next");

    // Asynchronous reset mid-frame
    send_beat("t5", 4'b1111, 1'b0, 1'b0, c);
    send_beat("t5", 4'b1111, 1'b0, 1'b0, c);
    #2 rst = 1'b1;
    #1;
    chk("t5.rst_valid",    out_valid, 0);
    chk("t5.rst_in_ready", in_ready,  0);
    chk("t5.rst_ones",     out_ones,  0);
    chk("t5.rst_words",    out_words, 0);
    frame.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5.no_spurious", out_valid, 0);
    send_beat("t5.after", 4'b1010, 1'b1, 1'b0, c);
    chk("t5.ones_const",  out_ones,  2);
    chk("t5.words_const", out_words, 1);

    // Every 4-bit value as a single-beat frame
    for (int x = 0; x < 16; x++) begin
      d = x[WIDTH-1:0];
      send_beat("t6", d, 1'b1, 1'b0, c);
    end

    // Randomised frames with random result stalls
    for (int i = 0; i < 80; i++) begin
      d  = WIDTH'($urandom_range(0, 15));
      l  = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 3) == 0);
      send_beat("rnd", d, l, st, c);
      if (!c) out_ready = 1'b1;
      else if (st) begin
        k = $urandom_range(1, 3);
        repeat (k) begin
          @(negedge clk);
          chk("rnd.hold_valid", out_valid, 1);
          chk("rnd.hold_ones",  out_ones,  e_ones);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("rnd.drop_valid", out_valid, 0);
      end
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", total_checks - fail_checks, total_checks);
    $finish;
  end

endmodule
